// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared opcodes, FSM states, mux encodings and instruction class type
package cpu_ctrl_pkg;
  localparam int OPCODE_W = 4;
  localparam int ALUOP_W = 2;
  localparam logic [OPCODE_W-1:0] OP_R = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_LD = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_ST = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_BEQ = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_JMP = 4'h5;
  localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;
  localparam logic [ALUOP_W-1:0] ALU_ADD = 2'b00;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 2'b01;
  localparam logic [ALUOP_W-1:0] ALU_FUNC = 2'b10;
  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] PC_ALU = 2'b00;
  localparam logic [1:0] PC_BR = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;
  typedef enum logic [3:0] {
    RST_IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD,
    MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, HALT
  } state_t;
  typedef struct packed {
    logic r, ld, st, addi, beq, jmp, hlt, ill;
  } iclass_t;
endpackage

// File: rtl/main_control_fsm_if.sv
// main_control_fsm_if: memory req/ready handshake (req, we, i_or_d to memory; ready back)
interface main_control_fsm_if;
  logic mem_req;
  logic mem_we;
  logic i_or_d;
  logic mem_ready;
  modport master(output mem_req, mem_we, i_or_d, input mem_ready);
  modport slave(input mem_req, mem_we, i_or_d, output mem_ready);
endinterface

// File: rtl/instr_class_decode.sv
// instr_class_decode: opcode_i -> one-hot instruction class cls_o
module instr_class_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode_i,
  output iclass_t             cls_o
);
  assign cls_o.r = opcode_i == OP_R;
  assign cls_o.ld = opcode_i == OP_LD;
  assign cls_o.st = opcode_i == OP_ST;
  assign cls_o.addi = opcode_i == OP_ADDI;
  assign cls_o.beq = opcode_i == OP_BEQ;
  assign cls_o.jmp = opcode_i == OP_JMP;
  assign cls_o.hlt = opcode_i == OP_HLT;
  assign cls_o.ill = ~|{cls_o.r, cls_o.ld, cls_o.st, cls_o.addi, cls_o.beq, cls_o.jmp, cls_o.hlt};
endmodule

// File: rtl/main_control_fsm.sv
// main_control_fsm: multi-cycle main control; clk/rst_n, opcode_i/zero_i in, memory handshake on mem, datapath controls out
module main_control_fsm
  import cpu_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic                zero_i,
  main_control_fsm_if.master  mem,
  output logic                ir_we_o,
  output logic                pc_we_o,
  output logic [1:0]          pc_src_o,
  output logic                reg_we_o,
  output logic                reg_dst_o,
  output logic                mem_to_reg_o,
  output logic                alu_src_a_o,
  output logic [1:0]          alu_src_b_o,
  output logic [ALUOP_W-1:0]  alu_op_o,
  output logic                halted_o,
  output logic                illegal_o
);
  state_t state_q, state_d;
  logic rdst_q, rdst_d, ill_q, ill_d;
  iclass_t cls;
  instr_class_decode u_dec (.opcode_i(opcode_i), .cls_o(cls));
  assign illegal_o = ill_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= RST_IDLE;
      rdst_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rdst_q <= rdst_d;
      ill_q <= ill_d;
    end
  always_comb begin
    state_d = state_q;
    rdst_d = rdst_q;
    ill_d = ill_q;
    mem.mem_req = 1'b0;
    mem.mem_we = 1'b0;
    mem.i_or_d = 1'b0;
    ir_we_o = 1'b0;
    pc_we_o = 1'b0;
    pc_src_o = PC_ALU;
    reg_we_o = 1'b0;
    reg_dst_o = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_a_o = 1'b0;
    alu_src_b_o = SRCB_REGB;
    alu_op_o = ALU_ADD;
    halted_o = 1'b0;
    case (state_q)
      RST_IDLE: state_d = FETCH;
      FETCH: begin
        mem.mem_req = 1'b1;
        alu_src_b_o = SRCB_ONE;
        ir_we_o = mem.mem_ready;
        pc_we_o = mem.mem_ready;
        state_d = mem.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b_o = SRCB_IMM;
        ill_d = ill_q | cls.ill;
        state_d = cls.r ? EXEC_R : (cls.ld | cls.st) ? MEM_ADDR : cls.addi ? EXEC_I :
                  cls.beq ? BRANCH : cls.jmp ? JUMP : HALT;
      end
      EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_op_o = ALU_FUNC;
        rdst_d = 1'b1;
        state_d = WB_ALU;
      end
      EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        rdst_d = 1'b0;
        state_d = WB_ALU;
      end
      MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        state_d = cls.st ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem.mem_req = 1'b1;
        mem.i_or_d = 1'b1;
        state_d = mem.mem_ready ? WB_MEM : MEM_RD;
      end
      MEM_WR: begin
        mem.mem_req = 1'b1;
        mem.mem_we = 1'b1;
        mem.i_or_d = 1'b1;
        state_d = mem.mem_ready ? FETCH : MEM_WR;
      end
      WB_ALU: begin
        reg_we_o = 1'b1;
        reg_dst_o = rdst_q;
        state_d = FETCH;
      end
      WB_MEM: begin
        reg_we_o = 1'b1;
        mem_to_reg_o = 1'b1;
        state_d = FETCH;
      end
      BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o = ALU_SUB;
        pc_src_o = PC_BR;
        pc_we_o = zero_i;
        state_d = FETCH;
      end
      JUMP: begin
        pc_src_o = PC_JMP;
        pc_we_o = 1'b1;
        state_d = FETCH;
      end
      HALT: halted_o = 1'b1;
      default: state_d = RST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_main_control_fsm.sv
// tb_main_control_fsm: scoreboard bench; stimulus queues expected outputs, negedge monitor compares
module tb_main_control_fsm;
  typedef enum {P_IDLE, P_FETCH, P_DEC, P_EXR, P_EXI, P_MA, P_MR, P_MW, P_WBA_R, P_WBA_I,
                P_WBM, P_BR, P_JMP, P_HLT} ph_t;
  typedef struct packed {
    logic req, we, iod, irw, pcw;
    logic [1:0] pcs;
    logic rw, rd, m2r, sa;
    logic [1:0] sb, aop;
    logic hlt, ill;
  } ov_t;
  typedef struct {ph_t p; ov_t v;} ent_t;
  logic clk = 0, rst_n = 0, zero = 0;
  logic [3:0] opcode = 0;
  logic ir_we, pc_we, reg_we, reg_dst, mem_to_reg, alu_src_a, halted, illegal;
  logic [1:0] pc_src, alu_src_b, alu_op;
  ent_t q[$];
  int n_cmp = 0, n_bad = 0;
  main_control_fsm_if bus();
  main_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode_i(opcode), .zero_i(zero), .mem(bus.master),
    .ir_we_o(ir_we), .pc_we_o(pc_we), .pc_src_o(pc_src), .reg_we_o(reg_we),
    .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg), .alu_src_a_o(alu_src_a),
    .alu_src_b_o(alu_src_b), .alu_op_o(alu_op), .halted_o(halted), .illegal_o(illegal)
  );
  always #5 clk = ~clk;
  function automatic ov_t e(ph_t p, logic z, logic r, logic il);
    ov_t o = '0;
    case (p)
      P_FETCH: begin o.req = 1; o.sb = 2'b01; o.irw = r; o.pcw = r; end
      P_DEC: o.sb = 2'b10;
      P_EXR: begin o.sa = 1; o.aop = 2'b10; end
      P_EXI, P_MA: begin o.sa = 1; o.sb = 2'b10; end
      P_MR: begin o.req = 1; o.iod = 1; end
      P_MW: begin o.req = 1; o.we = 1; o.iod = 1; end
      P_WBA_R: begin o.rw = 1; o.rd = 1; end
      P_WBA_I: o.rw = 1;
      P_WBM: begin o.rw = 1; o.m2r = 1; end
      P_BR: begin o.sa = 1; o.aop = 2'b01; o.pcs = 2'b01; o.pcw = z; end
      P_JMP: begin o.pcs = 2'b10; o.pcw = 1; end
      P_HLT: o.hlt = 1;
      default: ;
    endcase
    o.ill = il;
    return o;
  endfunction
  task automatic st(ph_t p, logic [3:0] op, logic z = 0, logic r = 1, logic il = 0);
    @(posedge clk); #1;
    opcode = op; zero = z; bus.mem_ready = r;
    q.push_back('{p, e(p, z, r, il)});
  endtask
  task automatic rst_cyc(logic lvl);
    @(posedge clk); #1;
    rst_n = lvl; bus.mem_ready = 0;
    q.push_back('{P_IDLE, ov_t'('0)});
  endtask
  always @(negedge clk)
    if (q.size() != 0) begin
      ent_t x;
      ov_t g;
      x = q.pop_front();
      g = '{bus.mem_req, bus.mem_we, bus.i_or_d, ir_we, pc_we, pc_src, reg_we, reg_dst,
            mem_to_reg, alu_src_a, alu_src_b, alu_op, halted, illegal};
      n_cmp++;
      if (g !== x.v) begin
        n_bad++;
        $display("FAIL %s @%0t got=%b exp=%b", x.p.name(), $time, g, x.v);
      end
    end
  initial begin
    bus.mem_ready = 0;
    repeat (2) @(posedge clk);
    rst_cyc(1);
    st(P_FETCH, 4'h0); st(P_DEC, 4'h0); st(P_EXR, 4'h0); st(P_WBA_R, 4'h0);
    st(P_FETCH, 4'h3, 0, 0); st(P_FETCH, 4'h3); st(P_DEC, 4'h3); st(P_EXI, 4'h3); st(P_WBA_I, 4'h3);
    st(P_FETCH, 4'h2); st(P_DEC, 4'h2); st(P_MA, 4'h2); st(P_MW, 4'h2, 0, 0); st(P_MW, 4'h2);
    st(P_FETCH, 4'h1); st(P_DEC, 4'h1); st(P_MA, 4'h1);
    repeat (3) st(P_MR, 4'h1, 0, 0);
    st(P_MR, 4'h1); st(P_WBM, 4'h1);
    st(P_FETCH, 4'h4); st(P_DEC, 4'h4); st(P_BR, 4'h4, 1);
    st(P_FETCH, 4'h4); st(P_DEC, 4'h4); st(P_BR, 4'h4, 0);
    st(P_FETCH, 4'h5); st(P_DEC, 4'h5); st(P_JMP, 4'h5);
    st(P_FETCH, 4'h0, 0, 0);
    rst_cyc(0); rst_cyc(0); rst_cyc(1);
    st(P_FETCH, 4'hA); st(P_DEC, 4'hA);
    for (int i = 0; i < 6; i++) st(P_HLT, 4'hA, 0, i[0], 1);
    rst_cyc(0); rst_cyc(1);
    st(P_FETCH, 4'hF); st(P_DEC, 4'hF);
    for (int i = 0; i < 20; i++) st(P_HLT, 4'hF, 0, i[0]);
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/main_control_fsm.md
Name: main_control_fsm

Overview:
- Multi-cycle main control unit of the 8-bit processor; sits directly upstream of the ALU control stage.
- Sequences fetch/decode/execute/memory/writeback per instruction from the 4-bit opcode.
- Drives the 2-bit alu_op class consumed by ALU control: 00 = address add, 01 = subtract/compare, 10 = use func field.
- Also drives PC, IR, register-file and memory-interface control; memory uses a req/ready handshake.

Parameters:
- OPCODE_W, 4, opcode width (instr[15:12]); fixed encoding below.
- ALUOP_W, 2, width of alu_op class output.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  4  IR[15:12]; valid from DECODE onward.
- zero  in  1  ALU zero flag, sampled in BRANCH.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request; held until mem_ready.
- mem_we  out  1  write qualifier for mem_req.
- i_or_d  out  1  0 = address from PC, 1 = address from ALUOut.
- ir_we  out  1  load instruction register.
- pc_we  out  1  PC write enable.
- pc_src  out  2  00 = ALU result, 01 = branch target (ALUOut), 10 = jump target.
- reg_we  out  1  register-file write.
- reg_dst  out  1  0 = rt, 1 = rd.
- mem_to_reg  out  1  writeback source: 1 = MDR.
- alu_src_a  out  1  0 = PC, 1 = reg A.
- alu_src_b  out  2  00 = reg B, 01 = const 1, 10 = sign-extended imm.
- alu_op  out  2  class to ALU control.
- halted  out  1  core stopped.
- illegal  out  1  sticky; set when an undefined opcode is decoded.

Behaviour:
- Opcodes: 0000 R-type, 0001 LOAD, 0010 STORE, 0011 ADDI, 0100 BEQ, 0101 JMP, 1111 HALT; all others illegal.
- States: RST_IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, HALT.
- Reset: async to RST_IDLE. All outputs are 0 in RST_IDLE, illegal is cleared, and mem_req drops immediately, including mid-handshake. RST_IDLE -> FETCH unconditionally.
- Outputs are Moore (decoded from state) except ir_we, pc_we and the BRANCH pc_we as noted.
- FETCH:
  - Drives mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - Stays while mem_ready=0.
  - When mem_ready=1: ir_we=1 and pc_we=1 (PC+1), then -> DECODE.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=10, alu_op=00 (branch target precompute).
  - Next state: R -> EXEC_R; LOAD/STORE -> MEM_ADDR; ADDI -> EXEC_I; BEQ -> BRANCH; JMP -> JUMP; HALT -> HALT.
  - Illegal opcode: set illegal, -> HALT.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10; -> WB_ALU with reg_dst=1.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00; -> WB_ALU with reg_dst=0.
- WB_ALU: reg_we=1, mem_to_reg=0; reg_dst held per source state via a registered flag; -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; LOAD -> MEM_RD, STORE -> MEM_WR.
- MEM_RD: mem_req=1, i_or_d=1; waits for mem_ready; -> WB_MEM.
- MEM_WR: mem_req=1, mem_we=1, i_or_d=1; waits for mem_ready; -> FETCH.
- WB_MEM: reg_we=1, mem_to_reg=1, reg_dst=0; -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_we=zero (Mealy); -> FETCH.
- JUMP: pc_src=10, pc_we=1; -> FETCH.
- HALT: halted=1; all enables 0; absorbing until reset.
- Latency with zero-wait memory: R/ADDI/STORE 4 cycles, LOAD 5, BEQ/JMP 3. Each mem_ready wait cycle adds 1.
- mem_ready while mem_req=0 is ignored. mem_req never deasserts before mem_ready except on reset.
- alu_op is never 11. Default (unreachable) state -> RST_IDLE.

Decomposition:
- Shared package cpu_ctrl_pkg:
  - opcode constants;
  - state enum;
  - alu_op class constants (ALU_ADD=00, ALU_SUB=01, ALU_FUNC=10);
  - alu_src_b and pc_src encodings.
- Sub-module: instr_class_decode (combinational), opcode -> one-hot class {r, ld, st, addi, beq, jmp, hlt, ill}.

Test Plan:
- Reset asserted mid-FETCH with mem_req=1 -> mem_req=0 the same cycle; all outputs 0 in RST_IDLE; FETCH one cycle after release.
- R-type (0000), mem_ready tied 1:
  - 4-cycle sequence FETCH, DECODE, EXEC_R, WB_ALU;
  - alu_op=10 in EXEC_R;
  - reg_we=1 and reg_dst=1 in WB_ALU only.
- LOAD with mem_ready delayed 3 cycles in MEM_RD -> mem_req held 3 cycles; WB_MEM has reg_we=1, mem_to_reg=1; total 8 cycles.
- BEQ with zero=1 then zero=0 -> alu_op=01 in BRANCH; pc_we=1 with pc_src=01 only when zero=1.
- Opcode 1010 -> illegal=1 and halted=1 after DECODE; no further mem_req; both clear only on rst_n low.
- HALT (1111) -> halted=1 held 20 cycles with mem_ready toggling; state unchanged.
